// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches and buffers
// returned words in order for decode, squashing stale fetches on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q;
    logic [31:0]   resp_pc_q;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] out_q;
    logic [CW-1:0] drop_q;

    logic [CW:0]   used;
    logic          req_fire;
    logic          resp_ok;
    logic          push;
    logic          pop;
    logic [31:0]   target;
    logic          unused_tgt;

    assign target     = {redirect_target[31:2], 2'b00};
    assign unused_tgt = ^redirect_target[1:0];

    // Credit covers both buffered words and fetches still in flight.
    assign used     = {1'b0, count_q} + {1'b0, out_q};
    assign imem_req_valid = !rst && !redirect_valid
                          && (used < (CW + 1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire = imem_req_valid && imem_req_ready;

    assign resp_ok = imem_resp_valid && (out_q != '0);
    assign push    = resp_ok && (drop_q == '0) && !redirect_valid;

    assign dec_valid = !rst && (count_q != '0) && !redirect_valid;
    assign dec_pc    = pc_mem[head_q];
    assign dec_instr = ins_mem[head_q];
    assign pop       = dec_valid && dec_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            out_q     <= '0;
            drop_q    <= '0;
        end else begin
            out_q <= out_q + CW'(req_fire) - CW'(resp_ok);
            if (redirect_valid) begin
                // Every fetch still in flight now belongs to the old path.
                pc_q      <= target;
                resp_pc_q <= target;
                head_q    <= '0;
                tail_q    <= '0;
                count_q   <= '0;
                drop_q    <= out_q - CW'(resp_ok);
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (resp_ok && (drop_q != '0)) begin
                    drop_q <= drop_q - 1'b1;
                end
                if (push) begin
                    pc_mem[tail_q]  <= resp_pc_q;
                    ins_mem[tail_q] <= imem_resp_data;
                    tail_q          <= tail_q + 1'b1;
                    resp_pc_q       <= resp_pc_q + 32'd4;
                end
                if (pop) begin
                    head_q <= head_q + 1'b1;
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against an epoch-tagged queue model
// with an in-order, variable-latency instruction memory.
module tb_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_pc          (dec_pc),
        .dec_instr       (dec_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          rdy;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] bufq[$];
    logic [31:0] mpc;
    int          ep;
    int          cyc;
    int          checks;
    int          failures;

    int          p_rdy;
    int          p_dec;
    int          p_redir;
    int          p_stray;
    int          lat_lo;
    int          lat_hi;
    bit          do_redir;
    logic [31:0] redir_tgt;

    function automatic logic [31:0] word_at(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(bit r);
        bit          exp_req;
        bit          exp_dec;
        bit          real_resp;
        mreq_t       m;
        @(negedge clk);
        rst             = r;
        imem_req_ready  = ($urandom_range(99) < p_rdy);
        dec_ready       = ($urandom_range(99) < p_dec);
        redirect_valid  = !r && (do_redir || ($urandom_range(999) < p_redir));
        redirect_target = do_redir ? redir_tgt : $urandom;
        do_redir        = 1'b0;
        real_resp       = !r && (memq.size() > 0) && (memq[0].rdy <= cyc);
        if (real_resp) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word_at(memq[0].addr);
        end else if (!r && memq.size() == 0 && $urandom_range(99) < p_stray) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = $urandom;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        exp_req = !r && !redirect_valid && (bufq.size() + memq.size() < DEPTH);
        exp_dec = !r && !redirect_valid && (bufq.size() != 0);
        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req && imem_req_valid)
            check("req_addr", imem_req_addr, mpc);
        check("dec_valid", 32'(dec_valid), 32'(exp_dec));
        if (exp_dec && dec_valid) begin
            check("dec_pc", dec_pc, bufq[0]);
            check("dec_instr", dec_instr, word_at(bufq[0]));
        end
        if (r) begin
            memq.delete();
            bufq.delete();
            mpc = RST_PC;
            ep++;
        end else begin
            if (exp_dec && dec_ready)
                void'(bufq.pop_front());
            if (real_resp) begin
                m = memq.pop_front();
                if (!redirect_valid && m.ep == ep)
                    bufq.push_back(m.addr);
            end
            if (exp_req && imem_req_ready) begin
                memq.push_back('{mpc, ep, cyc + int'($urandom_range(lat_hi, lat_lo))});
                mpc = mpc + 32'd4;
            end
            if (redirect_valid) begin
                bufq.delete();
                ep++;
                mpc = {redirect_target[31:2], 2'b00};
            end
        end
        cyc++;
    endtask

    task automatic redirect_to(logic [31:0] t);
        do_redir  = 1'b1;
        redir_tgt = t;
        step(1'b0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        cyc             = 0;
        ep              = 0;
        mpc             = RST_PC;
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        dec_ready       = 1'b0;
        do_redir        = 1'b0;
        redir_tgt       = '0;
        p_rdy   = 100;
        p_dec   = 100;
        p_redir = 0;
        p_stray = 0;
        lat_lo  = 1;
        lat_hi  = 1;

        repeat (3) step(1'b1);
        repeat (30) step(1'b0);

        p_dec = 0;
        repeat (10) step(1'b0);
        p_dec = 100;
        repeat (10) step(1'b0);

        lat_lo = 3;
        lat_hi = 3;
        repeat (6) step(1'b0);
        redirect_to(32'h0000_0103);
        repeat (15) step(1'b0);

        lat_lo = 1;
        lat_hi = 1;
        repeat (5) step(1'b0);
        redirect_to(32'h0000_0200);
        redirect_to(32'h0000_0301);
        repeat (3) step(1'b0);
        redirect_to(32'h0000_0400);
        repeat (10) step(1'b0);

        p_rdy = 0;
        repeat (5) step(1'b0);
        p_rdy = 100;
        repeat (10) step(1'b0);

        redirect_to(32'hFFFF_FFF8);
        repeat (12) step(1'b0);

        p_rdy   = 70;
        p_dec   = 70;
        p_redir = 40;
        p_stray = 3;
        lat_lo  = 1;
        lat_hi  = 4;
        repeat (1500) step(1'b0);
        repeat (2) step(1'b1);
        repeat (1500) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
